// File: rtl/mem_arbiter.sv
// Two-client (I-cache / D-cache) arbiter onto a single physical memory port.
// D side wins ties unless I has waited STARVE_LIMIT consecutive D grants.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_read,
  input  logic         i_write,
  input  logic [15:0]  i_address,
  input  logic [127:0] i_wdata,
  output logic [127:0] i_rdata,
  output logic         i_resp,
  input  logic         d_read,
  input  logic         d_write,
  input  logic [15:0]  d_address,
  input  logic [127:0] d_wdata,
  output logic [127:0] d_rdata,
  output logic         d_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [15:0]  pmem_address,
  output logic [127:0] pmem_wdata,
  input  logic [127:0] pmem_rdata,
  input  logic         pmem_resp
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state_q;
  logic           owner_q;
  logic [CW-1:0]  starve_q;
  logic [CW-1:0]  starve_d;
  logic           pmem_read_q;
  logic           pmem_write_q;
  logic [15:0]    pmem_address_q;
  logic [127:0]   pmem_wdata_q;
  logic           i_resp_q;
  logic           d_resp_q;
  logic [127:0]   i_rdata_q;
  logic [127:0]   d_rdata_q;

  logic           i_req;
  logic           d_req;
  logic           gnt_i_d;
  logic           gnt_wr_d;
  logic [15:0]    gnt_addr_d;
  logic [127:0]   gnt_wdata_d;

  always_comb begin
    i_req       = i_read | i_write;
    d_req       = d_read | d_write;
    gnt_i_d     = i_req && (!d_req || (starve_q == LIMIT));
    // A client asserting read and write together is treated as a write.
    gnt_wr_d    = gnt_i_d ? i_write : d_write;
    gnt_addr_d  = gnt_i_d ? i_address : d_address;
    gnt_wdata_d = gnt_i_d ? i_wdata : d_wdata;
    if (gnt_i_d || !i_req) begin
      starve_d = '0;
    end else if (starve_q == LIMIT) begin
      starve_d = starve_q;
    end else begin
      starve_d = starve_q + 1'b1;
    end
  end

  // The pmem outputs double as the latched request; they are only live in BUSY.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      owner_q        <= 1'b0;
      starve_q       <= '0;
      pmem_read_q    <= 1'b0;
      pmem_write_q   <= 1'b0;
      pmem_address_q <= '0;
      pmem_wdata_q   <= '0;
      i_resp_q       <= 1'b0;
      d_resp_q       <= 1'b0;
      i_rdata_q      <= '0;
      d_rdata_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (i_req || d_req) begin
            state_q        <= BUSY;
            owner_q        <= !gnt_i_d;
            starve_q       <= starve_d;
            pmem_read_q    <= !gnt_wr_d;
            pmem_write_q   <= gnt_wr_d;
            pmem_address_q <= gnt_addr_d;
            pmem_wdata_q   <= gnt_wdata_d;
          end
        end
        BUSY: begin
          if (pmem_resp) begin
            state_q        <= DONE;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= '0;
            pmem_wdata_q   <= '0;
            if (owner_q) begin
              d_resp_q  <= 1'b1;
              d_rdata_q <= pmem_rdata;
            end else begin
              i_resp_q  <= 1'b1;
              i_rdata_q <= pmem_rdata;
            end
          end
        end
        DONE: begin
          state_q   <= IDLE;
          i_resp_q  <= 1'b0;
          d_resp_q  <= 1'b0;
          i_rdata_q <= '0;
          d_rdata_q <= '0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pmem_read    = pmem_read_q;
  assign pmem_write   = pmem_write_q;
  assign pmem_address = pmem_address_q;
  assign pmem_wdata   = pmem_wdata_q;
  assign i_resp       = i_resp_q;
  assign d_resp       = d_resp_q;
  assign i_rdata      = i_rdata_q;
  assign d_rdata      = d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level arbitration model.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         i_read, i_write, d_read, d_write;
  logic [15:0]  i_address, d_address;
  logic [127:0] i_wdata, d_wdata;
  logic [127:0] i_rdata, d_rdata;
  logic         i_resp, d_resp;
  logic         pmem_read, pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int checks = 0;
  int errors = 0;

  int           mem_lat = 1;
  int           mem_cnt = 0;
  logic [127:0] mem_data = '0;
  logic         mem_noise = 1'b0;
  logic         resp_due = 1'b0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset_n(reset_n),
    .i_read(i_read), .i_write(i_write), .i_address(i_address), .i_wdata(i_wdata),
    .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Memory model: answers after mem_lat cycles of an active request.
  task automatic mem_drive();
    resp_due = 1'b0;
    if (pmem_read || pmem_write) begin
      mem_cnt++;
      if (mem_cnt == mem_lat) begin
        pmem_resp  = 1'b1;
        pmem_rdata = mem_data;
        resp_due   = 1'b1;
      end else begin
        pmem_resp  = 1'b0;
        pmem_rdata = rnd128();
      end
    end else begin
      mem_cnt    = 0;
      pmem_resp  = mem_noise ? 1'($urandom_range(0, 1)) : 1'b0;
      pmem_rdata = rnd128();
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    i_read = 0; i_write = 0; d_read = 0; d_write = 0;
    pmem_resp = 0; mem_cnt = 0; mem_noise = 0; resp_due = 0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    i_read = 1; i_write = 0; i_address = 16'h0AAA; i_wdata = rnd128();
    d_read = 1; d_write = 0; d_address = 16'h0BEE; d_wdata = rnd128();
    pmem_resp = 1; pmem_rdata = rnd128();
    repeat (2) @(negedge clk);
    checks++; if (pmem_read !== 1'b0) begin errors++; $display("FAIL reset_pmem_read: got %b want 0", pmem_read); end
    checks++; if (pmem_write !== 1'b0) begin errors++; $display("FAIL reset_pmem_write: got %b want 0", pmem_write); end
    checks++; if (pmem_address !== 16'h0) begin errors++; $display("FAIL reset_pmem_address: got %h want 0", pmem_address); end
    checks++; if (pmem_wdata !== 128'h0) begin errors++; $display("FAIL reset_pmem_wdata: got %h want 0", pmem_wdata); end
    checks++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin errors++; $display("FAIL reset_resp: got i=%b d=%b want 0 0", i_resp, d_resp); end
    checks++; if (i_rdata !== 128'h0 || d_rdata !== 128'h0) begin errors++; $display("FAIL reset_rdata: got i=%h d=%h want 0", i_rdata, d_rdata); end
    pmem_resp = 0;
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (pmem_read !== 1'b1 || pmem_address !== 16'h0BEE) begin errors++; $display("FAIL reset_first_grant: got read=%b addr=%h want 1 0bee", pmem_read, pmem_address); end
    do_reset();
  endtask

  task automatic test_d_read_only();
    int rd_cyc = 0, resp_cyc = 0, ibad = 0, abad = 0, wbad = 0;
    do_reset();
    mem_lat = 5; mem_data = {16{8'hA5}};
    d_read = 1; d_address = 16'h1230; d_wdata = rnd128();
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (pmem_read === 1'b1) begin rd_cyc++; if (pmem_address !== 16'h1230) abad++; end
      if (pmem_write !== 1'b0) wbad++;
      if (i_resp !== 1'b0) ibad++;
      if (d_resp === 1'b1) begin
        resp_cyc++;
        checks++; if (d_rdata !== {16{8'hA5}}) begin errors++; $display("FAIL dread_rdata: got %h want a5..a5", d_rdata); end
        d_read = 0;
      end
      mem_drive();
    end
    checks++; if (rd_cyc != 5) begin errors++; $display("FAIL dread_read_cycles: got %0d want 5", rd_cyc); end
    checks++; if (abad != 0) begin errors++; $display("FAIL dread_address: got %0d bad cycles want 0", abad); end
    checks++; if (resp_cyc != 1) begin errors++; $display("FAIL dread_resp_cycles: got %0d want 1", resp_cyc); end
    checks++; if (ibad != 0 || wbad != 0) begin errors++; $display("FAIL dread_other: got i_resp=%0d write=%0d cycles want 0", ibad, wbad); end
  endtask

  task automatic test_both_request();
    logic [15:0] addr_q[$];
    logic        wr_q[$];
    logic        prev = 0;
    int          idle_run = 0, gap = -1, d_at = -1, i_at = -1;
    logic        act;
    do_reset();
    mem_lat = 2; mem_data = rnd128();
    i_read = 1; i_address = 16'h1111; i_wdata = rnd128();
    d_write = 1; d_address = 16'h2222; d_wdata = rnd128();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      act = pmem_read | pmem_write;
      if (act && !prev) begin
        addr_q.push_back(pmem_address);
        wr_q.push_back(pmem_write);
        if (addr_q.size() == 2) gap = idle_run;
      end
      idle_run = act ? 0 : idle_run + 1;
      prev = act;
      if (d_resp === 1'b1) begin d_write = 0; d_at = c; end
      if (i_resp === 1'b1) begin i_read = 0; i_at = c; end
      mem_drive();
    end
    checks++; if (addr_q.size() != 2) begin errors++; $display("FAIL both_grant_count: got %0d want 2", addr_q.size()); end
    else begin
      checks++; if (addr_q[0] !== 16'h2222 || wr_q[0] !== 1'b1) begin errors++; $display("FAIL both_first: got addr=%h wr=%b want 2222 1", addr_q[0], wr_q[0]); end
      checks++; if (addr_q[1] !== 16'h1111 || wr_q[1] !== 1'b0) begin errors++; $display("FAIL both_second: got addr=%h wr=%b want 1111 0", addr_q[1], wr_q[1]); end
      checks++; if (gap < 2) begin errors++; $display("FAIL both_gap: got %0d idle cycles want >=2", gap); end
    end
    checks++; if (d_at < 0 || i_at <= d_at) begin errors++; $display("FAIL both_resp_order: got d=%0d i=%0d want d first", d_at, i_at); end
  endtask

  task automatic test_starvation();
    logic [15:0] addr_q[$];
    logic        prev = 0, act;
    do_reset();
    mem_lat = 1; mem_data = rnd128();
    i_read = 1; i_address = 16'h1111; i_wdata = rnd128();
    d_read = 1; d_address = 16'h2222; d_wdata = rnd128();
    for (int c = 0; c < 200 && addr_q.size() < 10; c++) begin
      @(negedge clk);
      act = pmem_read | pmem_write;
      if (act && !prev) addr_q.push_back(pmem_address);
      prev = act;
      mem_drive();
    end
    checks++; if (addr_q.size() != 10) begin errors++; $display("FAIL starve_grants: got %0d grants want 10", addr_q.size()); end
    else begin
      for (int k = 0; k < 10; k++) begin
        checks++;
        if (addr_q[k] !== ((k % (LIMIT + 1) == LIMIT) ? 16'h1111 : 16'h2222)) begin
          errors++; $display("FAIL starve_order[%0d]: got %h want %h", k, addr_q[k],
                             (k % (LIMIT + 1) == LIMIT) ? 16'h1111 : 16'h2222);
        end
      end
    end
    do_reset();
  endtask

  task automatic test_read_write_both();
    for (int side = 0; side < 2; side++) begin
      logic seen = 0, got = 0;
      do_reset();
      mem_lat = 2; mem_data = rnd128();
      if (side == 0) begin d_read = 1; d_write = 1; d_address = 16'h3000; d_wdata = {16{8'h0F}}; end
      else begin i_read = 1; i_write = 1; i_address = 16'h3001; i_wdata = {16{8'h0F}}; end
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (!seen && (pmem_read | pmem_write)) begin
          seen = 1;
          checks++; if (pmem_write !== 1'b1 || pmem_read !== 1'b0) begin errors++; $display("FAIL rw_op[%0d]: got r=%b w=%b want 0 1", side, pmem_read, pmem_write); end
          checks++; if (pmem_wdata !== {16{8'h0F}}) begin errors++; $display("FAIL rw_wdata[%0d]: got %h want 0f..0f", side, pmem_wdata); end
        end
        if (i_resp === 1'b1 || d_resp === 1'b1) begin got = 1; i_read = 0; i_write = 0; d_read = 0; d_write = 0; end
        mem_drive();
      end
      checks++; if (!seen || !got) begin errors++; $display("FAIL rw_complete[%0d]: got seen=%b resp=%b want 1 1", side, seen, got); end
    end
  endtask

  task automatic test_reset_mid_busy();
    logic seen = 0, got = 0;
    logic [127:0] exp;
    do_reset();
    mem_lat = 10; mem_data = rnd128();
    d_read = 1; d_address = 16'h5555; d_wdata = rnd128();
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      seen = pmem_read;
      mem_drive();
    end
    checks++; if (!seen) begin errors++; $display("FAIL midrst_start: got no pmem_read want 1"); end
    @(negedge clk); mem_drive();
    #2 reset_n = 1'b0;
    #1;
    checks++; if (pmem_read !== 1'b0 || pmem_write !== 1'b0) begin errors++; $display("FAIL midrst_pmem: got r=%b w=%b want 0 0", pmem_read, pmem_write); end
    checks++; if (i_resp !== 1'b0 || d_resp !== 1'b0 || pmem_address !== 16'h0) begin errors++; $display("FAIL midrst_outputs: got i=%b d=%b addr=%h want 0", i_resp, d_resp, pmem_address); end
    d_read = 0; pmem_resp = 0;
    @(negedge clk);
    reset_n = 1'b1;
    mem_lat = 1; exp = rnd128(); mem_data = exp; mem_cnt = 0; seen = 0;
    i_read = 1; i_address = 16'h4321; i_wdata = rnd128();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (pmem_read === 1'b1 && pmem_address === 16'h4321) seen = 1;
      if (i_resp === 1'b1) begin
        got = 1; i_read = 0;
        checks++; if (i_rdata !== exp) begin errors++; $display("FAIL midrst_rdata: got %h want %h", i_rdata, exp); end
      end
      mem_drive();
    end
    checks++; if (!seen || !got) begin errors++; $display("FAIL midrst_recover: got seen=%b resp=%b want 1 1", seen, got); end
  endtask

  task automatic test_addr_change();
    int act_cyc = 0, bad = 0;
    logic [127:0] w;
    do_reset();
    mem_lat = 6; mem_data = rnd128(); w = rnd128();
    d_write = 1; d_address = 16'h6789; d_wdata = w;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (pmem_write === 1'b1) begin
        act_cyc++;
        if (pmem_address !== 16'h6789 || pmem_wdata !== w) bad++;
        d_address = 16'($urandom); d_wdata = rnd128();
      end
      if (d_resp === 1'b1) d_write = 0;
      mem_drive();
    end
    checks++; if (act_cyc != 6) begin errors++; $display("FAIL addrchg_cycles: got %0d want 6", act_cyc); end
    checks++; if (bad != 0) begin errors++; $display("FAIL addrchg_latched: got %0d changed cycles want 0", bad); end
  endtask

  task automatic test_random();
    logic         i_pend = 0, d_pend = 0, owner = 0, c_wr = 0, exp_i;
    logic [1:0]   i_op = 0, d_op = 0;
    logic [15:0]  i_a = 0, d_a = 0, c_a = 0;
    logic [127:0] i_w = 0, d_w = 0, c_w = 0;
    logic         act, prev = 0, had_prev = 0;
    int           starve = 0, idle_run = 0, stall = 0, txns = 0;
    do_reset();
    mem_noise = 1;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      act = pmem_read | pmem_write;
      if (resp_due) begin
        checks++;
        if ((owner ? d_resp : i_resp) !== 1'b1 || (owner ? i_resp : d_resp) !== 1'b0) begin
          errors++; $display("FAIL rnd_resp: got i=%b d=%b want owner(d=%b) only", i_resp, d_resp, owner);
        end
        checks++;
        if ((owner ? d_rdata : i_rdata) !== mem_data || (owner ? i_rdata : d_rdata) !== 128'h0) begin
          errors++; $display("FAIL rnd_rdata: got i=%h d=%h want %h on owner(d=%b)", i_rdata, d_rdata, mem_data, owner);
        end
        if (owner) begin d_pend = 0; d_read = 0; d_write = 0; end
        else begin i_pend = 0; i_read = 0; i_write = 0; end
        txns++;
      end else begin
        checks++; if (i_resp !== 1'b0 || d_resp !== 1'b0) begin errors++; $display("FAIL rnd_spurious_resp: got i=%b d=%b want 0 0", i_resp, d_resp); end
      end
      if (act && !prev) begin
        checks++; if (!i_pend && !d_pend) begin errors++; $display("FAIL rnd_grant_no_req: got grant addr=%h want none", pmem_address); end
        exp_i = i_pend && (!d_pend || starve == LIMIT);
        if (exp_i) starve = 0;
        else starve = i_pend ? ((starve < LIMIT) ? starve + 1 : LIMIT) : 0;
        owner = !exp_i;
        c_a = exp_i ? i_a : d_a;
        c_w = exp_i ? i_w : d_w;
        c_wr = exp_i ? i_op[1] : d_op[1];
        checks++; if (pmem_write !== c_wr || pmem_read !== !c_wr) begin errors++; $display("FAIL rnd_op: got r=%b w=%b want w=%b", pmem_read, pmem_write, c_wr); end
        checks++; if (pmem_address !== c_a) begin errors++; $display("FAIL rnd_addr: got %h want %h (I won=%b)", pmem_address, c_a, exp_i); end
        checks++; if (pmem_wdata !== c_w) begin errors++; $display("FAIL rnd_wdata: got %h want %h", pmem_wdata, c_w); end
        if (had_prev) begin
          checks++; if (idle_run < 2) begin errors++; $display("FAIL rnd_gap: got %0d idle cycles want >=2", idle_run); end
        end
        had_prev = 1;
        mem_lat = $urandom_range(1, 4);
        mem_data = rnd128();
      end else if (act) begin
        checks++;
        if (pmem_write !== c_wr || pmem_read !== !c_wr || pmem_address !== c_a || pmem_wdata !== c_w) begin
          errors++; $display("FAIL rnd_hold: got r=%b w=%b addr=%h want w=%b addr=%h", pmem_read, pmem_write, pmem_address, c_wr, c_a);
        end
      end
      if (act) begin
        checks++; if ((owner ? i_rdata : d_rdata) !== 128'h0) begin errors++; $display("FAIL rnd_nonowner_rdata: got i=%h d=%h want 0 on non-owner", i_rdata, d_rdata); end
      end
      idle_run = act ? 0 : idle_run + 1;
      prev = act;
      stall = ((i_pend || d_pend) && !act) ? stall + 1 : 0;
      if (stall > 12) begin
        checks++; errors++; $display("FAIL rnd_stall: got %0d idle cycles with pending request want <=12", stall);
        break;
      end
      mem_drive();
      if (!i_pend && $urandom_range(0, 2) == 0) begin
        i_pend = 1; i_op = 2'($urandom_range(1, 3)); i_a = 16'($urandom); i_w = rnd128();
        i_read = i_op[0]; i_write = i_op[1]; i_address = i_a; i_wdata = i_w;
      end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; d_op = 2'($urandom_range(1, 3)); d_a = 16'($urandom); d_w = rnd128();
        d_read = d_op[0]; d_write = d_op[1]; d_address = d_a; d_wdata = d_w;
      end
    end
    checks++; if (txns < 100) begin errors++; $display("FAIL rnd_throughput: got %0d transactions want >=100", txns); end
  endtask

  initial begin
    reset_n = 1'b0;
    i_read = 0; i_write = 0; i_address = '0; i_wdata = '0;
    d_read = 0; d_write = 0; d_address = '0; d_wdata = '0;
    pmem_resp = 0; pmem_rdata = '0;
    test_reset();
    test_d_read_only();
    test_both_request();
    test_starvation();
    test_read_write_both();
    test_reset_mid_busy();
    test_addr_change();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
